// File: rtl/sa_fifo_ctrl_128x512_if.sv
// Valid/ready stream bundle for the FIFO controller: a write channel into the
// FIFO and a read channel out of it. The controller takes the slave view, and
// the producer/consumer side takes the master view.
interface sa_fifo_ctrl_128x512_if #(
  parameter int DW = 512
);
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  // Producer/consumer side: drives write beats and read acceptance.
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  // Controller side: accepts write beats and presents the FIFO head.
  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/sa_fifo_ctrl_128x512.sv
// FIFO controller around an external 128 x 512-bit RAM that has a registered
// read address (dout is valid the cycle after re). The controller owns the
// pointers, the occupancy counters, the read-issue scheduling and a 2-entry
// output buffer (head + skid). The buffer hides the RAM read latency and keeps
// one beat per cycle flowing under backpressure.
//
// Counters:
//   ram_cnt : slots written but not yet captured into the output buffer.
//             A slot is released only at capture, never at issue, so a write
//             can never land on the address held in the RAM's read register.
//   pend    : slots written but not yet read-issued.
//   inflight: a read was issued last cycle, so ram_dout is valid now.
//   ob_cnt  : output buffer occupancy, 0..2.
// DEPTH must equal 2**AW, so the pointers wrap naturally.
module sa_fifo_ctrl_128x512 #(
  parameter int DW    = 512,
  parameter int AW    = 7,
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  sa_fifo_ctrl_128x512_if.slave  fifo,
  output logic                   ram_we,
  output logic [AW-1:0]          ram_wa,
  output logic [DW-1:0]          ram_di,
  output logic                   ram_re,
  output logic [AW-1:0]          ram_ra,
  input  logic [DW-1:0]          ram_dout,
  output logic [AW+2:0]          level
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Registered state
  logic [AW-1:0] wptr_q,    rptr_q;
  logic [AW:0]   ram_cnt_q, pend_q;
  logic          inflight_q;
  logic [1:0]    ob_cnt_q;
  logic [DW-1:0] head_q,    skid_q;

  // Next-state values
  logic [AW-1:0] wptr_d,    rptr_d;
  logic [AW:0]   ram_cnt_d, pend_d;
  logic [1:0]    ob_cnt_d;
  logic [DW-1:0] head_d,    skid_d;

  // Per-cycle events
  logic       push;
  logic       pop;
  logic       issue;
  logic       capture;
  logic [2:0] ob_after;   // buffer + in-flight after this cycle's pop
  logic [1:0] ob_keep;    // buffer entries left after this cycle's pop

  // Handshakes and issue decision, all from registered state and inputs.
  always_comb begin
    fifo.wr_ready = !rst && (ram_cnt_q < DEPTH_C);
    fifo.rd_valid = (ob_cnt_q != 2'd0);
    fifo.rd_data  = head_q;

    push    = fifo.wr_valid && fifo.wr_ready;
    pop     = fifo.rd_valid && fifo.rd_ready;
    capture = inflight_q;

    // pop implies ob_cnt >= 1, so this cannot underflow.
    ob_after = 3'(ob_cnt_q) + 3'(inflight_q) - 3'(pop);
    ob_keep  = ob_cnt_q - 2'(pop);
    // Reset gating keeps re low while the pointers are being cleared.
    issue    = !rst && (pend_q != '0) && (ob_after < 3'd2);

    ram_we = push;
    ram_wa = wptr_q;
    ram_di = fifo.wr_data;
    ram_re = issue;
    ram_ra = rptr_q;

    level  = (AW+3)'(ram_cnt_q) + (AW+3)'(ob_cnt_q);
  end

  // Counter and pointer updates; every increment and decrement applies together.
  always_comb begin
    // NOTE: every variable assigned in this block gets a default first, so no
    // path through it can leave a value unassigned and infer a latch.
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q + (AW+1)'(push) - (AW+1)'(capture);
    pend_d    = pend_q    + (AW+1)'(push) - (AW+1)'(issue);
    ob_cnt_d  = ob_cnt_q  - 2'(pop)       + 2'(capture);
    if (push)  wptr_d = wptr_q + AW'(1);
    if (issue) rptr_d = rptr_q + AW'(1);
  end

  // Output buffer: shift on pop, then drop the capture into the first free slot.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (pop && (ob_cnt_q == 2'd2)) head_d = skid_q;
    // While a read is in flight the buffer holds at most one entry, so after
    // the pop at most one slot is in use and the capture always fits.
    if (capture) begin
      if (ob_keep == 2'd0) head_d = ram_dout;
      else                 skid_d = ram_dout;
    end
  end

  // Control state register with synchronous reset; in-flight data is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      pend_q     <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= '0;
      head_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      pend_q     <= pend_d;
      inflight_q <= issue;
      ob_cnt_q   <= ob_cnt_d;
      head_q     <= head_d;
    end
  end

  // Skid data register.
  always_ff @(posedge clk) begin
    // NOTE: the skid register is deliberately not reset; it is only read when
    // ob_cnt marks it as occupied, and that count is reset.
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_sa_fifo_ctrl_128x512.sv
// Self-checking bench for sa_fifo_ctrl_128x512 with a behavioural RAM that has
// a registered read address. A scoreboard queue receives each accepted beat
// and is popped on every read handshake. The bench also checks level against
// the queue size every cycle.
module tb_sa_fifo_ctrl_128x512;
  localparam int DW    = 512;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_fifo_ctrl_128x512_if #(.DW(DW)) bus ();

  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic [AW+2:0] level;

  sa_fifo_ctrl_128x512 #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .fifo     (bus),
    .ram_we   (ram_we),
    .ram_wa   (ram_wa),
    .ram_di   (ram_di),
    .ram_re   (ram_re),
    .ram_ra   (ram_ra),
    .ram_dout (ram_dout),
    .level    (level)
  );

  // RAM model: the write is synchronous, the read address is registered, and
  // dout reads the array live. A write to an in-flight read slot would corrupt
  // the data, and the scoreboard would catch it.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sb [$];
  bit            mon_en = 1'b0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] hold_data;
  bit            iss_prev = 1'b0;
  logic [AW-1:0] iss_addr;

  // Monitor at negedge: level vs model, hold stability, write/read-slot
  // collision, and in-order data on every pop.
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    if (rst) begin
      sb.delete();
      hold_prev = 1'b0;
      iss_prev  = 1'b0;
    end else if (mon_en) begin
      checks++;
      if (level !== (AW+3)'(sb.size())) begin
        failures++;
        $display("FAIL level_track: got %0d expected %0d at %0t", level, sb.size(), $time);
      end
      if (hold_prev) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== hold_data) begin
          failures++;
          $display("FAIL rd_hold_stable: got valid=%0b data=%0h expected valid=1 data=%0h",
                   bus.rd_valid, bus.rd_data, hold_data);
        end
      end
      if (ram_we && iss_prev) begin
        checks++;
        if (ram_wa === iss_addr) begin
          failures++;
          $display("FAIL wr_inflight_slot: got wa=%0d expected not %0d", ram_wa, iss_addr);
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected: got data=%0h expected no beat", bus.rd_data);
        end else begin
          exp_d = sb.pop_front();
          if (bus.rd_data !== exp_d) begin
            failures++;
            $display("FAIL pop_data: got %0h expected %0h", bus.rd_data, exp_d);
          end
        end
      end
      if (bus.wr_valid && bus.wr_ready) sb.push_back(bus.wr_data);
      hold_prev = bus.rd_valid && !bus.rd_ready;
      hold_data = bus.rd_data;
      iss_prev  = ram_re;
      iss_addr  = ram_ra;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int c;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    for (c = 0; c < 1000 && (level != '0 || bus.rd_valid); c++) tick();
    checks++;
    if (level !== '0 || bus.rd_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got level=%0d rd_valid=%0b sb=%0d expected 0/0/0",
               level, bus.rd_valid, sb.size());
    end
    bus.rd_ready = 1'b0;
  endtask

  // Push incrementing beats with rd_ready low until wr_ready drops.
  task automatic fill_full(input int base, output int acc);
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 400 && bus.wr_ready; c++) begin
      bus.wr_data = DW'(base + acc);
      tick();
      acc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.wr_ready !== 1'b0 || bus.rd_valid !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got wr_ready=%0b rd_valid=%0b we=%0b re=%0b expected all 0",
               bus.wr_ready, bus.rd_valid, ram_we, ram_re);
    end
    checks++;
    if (level !== '0 || bus.rd_data !== '0) begin
      failures++;
      $display("FAIL reset_level_data: got level=%0d data=%0h expected 0/0", level, bus.rd_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_wr_ready: got %0b expected 1", bus.wr_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] pat;
    pat = {64{8'hA5}};
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_data  = pat;
    bus.rd_ready = 1'b1;
    tick();                                   // T+1
    bus.wr_valid = 1'b0;
    checks++;
    if (ram_re !== 1'b1 || ram_ra !== '0) begin
      failures++;
      $display("FAIL single_issue: got re=%0b ra=%0d expected re=1 ra=0", ram_re, ram_ra);
    end
    tick();                                   // T+2
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_valid: got %0b expected 0", bus.rd_valid);
    end
    tick();                                   // T+3
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== pat) begin
      failures++;
      $display("FAIL single_out: got valid=%0b data=%0h expected 1/%0h", bus.rd_valid, bus.rd_data, pat);
    end
    tick();                                   // T+4, popped
    checks++;
    if (level !== '0 || bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after_pop: got level=%0d valid=%0b expected 0/0", level, bus.rd_valid);
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_fill();
    int acc;
    fill_full(32'h1000, acc);
    checks++;
    if (acc != DEPTH + 2 || level !== 10'(DEPTH + 2)) begin
      failures++;
      $display("FAIL fill_count: got acc=%0d level=%0d expected %0d", acc, level, DEPTH + 2);
    end
    bus.wr_data = DW'(32'h1000 + acc);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.wr_ready !== 1'b0) begin
        failures++;
        $display("FAIL fill_held: got wr_ready=%0b expected 0", bus.wr_ready);
      end
    end
    bus.rd_ready = 1'b1;
    tick();                                   // pop done, capture next
    bus.rd_ready = 1'b0;
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_ready_early: got %0b expected 0", bus.wr_ready);
    end
    tick();
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_ready_after_capture: got %0b expected 1", bus.wr_ready);
    end
    tick();                                   // 131st beat accepted
    bus.wr_valid = 1'b0;
    checks++;
    if (level !== 10'(DEPTH + 2)) begin
      failures++;
      $display("FAIL fill_level_131: got %0d expected %0d", level, DEPTH + 2);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int last  = -1;
    int outs  = 0;
    int stalls = 0;
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 520; c++) begin
      bus.wr_valid = (c < 512);
      bus.wr_data  = DW'(c);
      #0;
      if (bus.wr_valid && !bus.wr_ready) stalls++;
      if (bus.rd_valid) begin
        if (first < 0) first = c;
        last = c;
        outs++;
      end
      tick();
    end
    checks++;
    if (first != 3 || outs != 512 || last != first + 511) begin
      failures++;
      $display("FAIL stream_timing: got first=%0d outs=%0d last=%0d expected 3/512/514", first, outs, last);
    end
    checks++;
    if (stalls != 0) begin
      failures++;
      $display("FAIL stream_wr_stall: got %0d expected 0", stalls);
    end
    drain();
  endtask

  task automatic test_random();
    int pushed = 0;
    int c;
    logic [DW-1:0] d;
    for (c = 0; c < 60000 && pushed < 10000; c++) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
      bus.wr_data  = d;
      bus.wr_valid = ($urandom_range(0, 1) == 1);
      bus.rd_ready = ($urandom_range(0, 1) == 1);
      #0;
      if (bus.wr_valid && bus.wr_ready) pushed++;
      tick();
    end
    checks++;
    if (pushed != 10000) begin
      failures++;
      $display("FAIL random_budget: got %0d beats expected 10000", pushed);
    end
    drain();
  endtask

  task automatic test_reset_mid_stream();
    int c;
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.wr_data = DW'(32'h5000 + i);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (level !== 10'd40) begin
      failures++;
      $display("FAIL mid_level40: got %0d expected 40", level);
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = DW'(32'h5999);
    bus.rd_ready = 1'b1;
    #0;
    checks++;
    if (ram_re !== 1'b1) begin
      failures++;
      $display("FAIL mid_issue: got re=%0b expected 1", ram_re);
    end
    tick();                                   // issue now in flight
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    rst = 1'b1;
    #0;
    checks++;
    if (level !== 10'd40) begin
      failures++;
      $display("FAIL mid_level_before_rst: got %0d expected 40", level);
    end
    tick();
    rst = 1'b0;
    #0;
    checks++;
    if (level !== '0 || bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_after_rst: got level=%0d valid=%0b wr_ready=%0b expected 0/0/1",
               level, bus.rd_valid, bus.wr_ready);
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = DW'(1);
    tick();
    bus.wr_valid = 1'b0;
    for (c = 0; c < 10 && !bus.rd_valid; c++) tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(1)) begin
      failures++;
      $display("FAIL mid_first_out: got valid=%0b data=%0h expected 1/1", bus.rd_valid, bus.rd_data);
    end
    drain();
  endtask

  task automatic test_full_pop();
    int acc;
    fill_full(32'h9000, acc);
    checks++;
    if (acc != DEPTH + 2) begin
      failures++;
      $display("FAIL fullpop_fill: got %0d expected %0d", acc, DEPTH + 2);
    end
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.wr_data = DW'(32'h9000 + acc);
      #0;
      checks++;
      if (bus.wr_ready !== (c >= 2)) begin
        failures++;
        $display("FAIL fullpop_ready_c%0d: got %0b expected %0b", c, bus.wr_ready, (c >= 2));
      end
      if (bus.wr_ready) acc++;
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid_stream();
    test_full_pop();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
